// File: rtl/pc_sequencer_pkg.sv
// pkg_cpu: shared opcodes, sequencer state encoding and instruction field slices
package pkg_cpu;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_BZ   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_WAIT   = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_HALTED = 3'd4;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_NOP, OP_ALU, OP_LDI, OP_JMP, OP_BZ, OP_HALT};
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake (req out, valid/data back)
interface pc_sequencer_if #(parameter int INSTR_W = 16);
  logic imem_req;
  logic imem_valid;
  logic [INSTR_W-1:0] imem_data;
  modport master(output imem_req, input imem_valid, input imem_data);
  modport slave(input imem_req, output imem_valid, output imem_data);
endinterface

// File: rtl/pc_sequencer_fetch_timer.sv
// fetch_timer: counts WAIT cycles without imem_valid; expire flags the final allowed cycle
// Ports: clk, reset (sync, active-high), clr (zero the count), inc (count one cycle), expire
module fetch_timer #(parameter int LIMIT = 15) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  // The increment that would reach LIMIT is the faulting one, so expire one count early
  assign expire = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute control FSM for the 8-bit soft processor
// Ports: clk, reset (sync, active-high), stall (freeze), imem (fetch handshake, master side),
//        zero_flag (ALU zero for BZ), pc_en/pc_ld/pc_target (PC control), ir, alu_op,
//        rf_we (register-file write), retired (instruction count), halted, fault
module pc_sequencer
  import pkg_cpu::*;
#(
  parameter int INSTR_W       = 16,
  parameter int FETCH_TIMEOUT = 15,
  parameter int RET_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 zero_flag,
  pc_sequencer_if.master       imem,
  output logic                 pc_en,
  output logic                 pc_ld,
  output logic [7:0]           pc_target,
  output logic [INSTR_W-1:0]   ir,
  output logic [3:0]           alu_op,
  output logic                 rf_we,
  output logic [RET_CNT_W-1:0] retired,
  output logic                 halted,
  output logic                 fault
);
  state_t state, nxt;
  logic fetch_st, wait_st, dec_st, exec_st, go, load, jump, expire;
  assign fetch_st = state == S_FETCH;
  assign wait_st  = state == S_WAIT;
  assign dec_st   = state == S_DECODE;
  assign exec_st  = state == S_EXEC;
  assign go       = !stall;
  assign alu_op   = ir[OPC_HI:OPC_LO];
  assign pc_target = ir[IMM_HI:IMM_LO];
  // imem_valid is only honoured when not stalled
  assign load = (fetch_st || wait_st) && imem.imem_valid && go;
  assign jump = exec_st && go && (alu_op == OP_JMP || (alu_op == OP_BZ && zero_flag));
  assign imem.imem_req = fetch_st || wait_st;
  assign pc_en  = load || jump;
  assign pc_ld  = jump;
  assign rf_we  = exec_st && go && (alu_op == OP_ALU || alu_op == OP_LDI);
  assign halted = state == S_HALTED;
  fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(fetch_st),
    .inc(wait_st && go && !imem.imem_valid),
    .expire(expire)
  );
  always_comb
    nxt = halted   ? S_HALTED :
          stall    ? state :
          fetch_st ? (imem.imem_valid ? S_DECODE : S_WAIT) :
          wait_st  ? (imem.imem_valid ? S_DECODE : expire ? S_HALTED : S_WAIT) :
          dec_st   ? (is_legal(alu_op) ? S_EXEC : S_HALTED) :
          exec_st  ? (alu_op == OP_HALT ? S_HALTED : S_FETCH) :
                     S_FETCH;
  always_ff @(posedge clk)
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      retired <= '0;
      fault   <= 1'b0;
    end else begin
      state <= nxt;
      if (load) ir <= imem.imem_data;
      if (exec_st && go) retired <= retired + 1'b1;
      if (go && ((wait_st && !imem.imem_valid && expire) || (dec_st && !is_legal(alu_op))))
        fault <= 1'b1;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/execute control FSM for the 8-bit soft processor.
- Drives the program counter's enable, load and load-address inputs, the instruction-memory request handshake, the instruction register and register-file write strobe.
- Sits between the PC and imem on one side and the ALU/register file on the other.
- One instruction is retired per FETCH→WAIT→DECODE→EXEC pass.

Parameters:
- INSTR_W, 16, instruction width; opcode = instr[15:12], imm8 = instr[7:0].
- FETCH_TIMEOUT, 15, max cycles in WAIT without imem_valid before fault (range 1..255).
- RET_CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; all state updates on rising edge of clk.
- stall  in  1  freeze request from external hazard logic.
- imem_valid  in  1  instruction data valid.
- imem_data  in  INSTR_W  fetched instruction.
- zero_flag  in  1  ALU zero flag, used by BZ.
- imem_req  out  1  fetch request; PC value is the address.
- pc_en  out  1  PC enable.
- pc_ld  out  1  PC load select (1 = load pc_target, 0 = increment).
- pc_target  out  8  signed absolute jump target = imm8.
- ir  out  INSTR_W  instruction register.
- alu_op  out  4  opcode forwarded to ALU, = ir[15:12].
- rf_we  out  1  register-file write strobe.
- retired  out  RET_CNT_W  retired-instruction count.
- halted  out  1  core stopped (HALT executed or fault).
- fault  out  1  fetch timeout or illegal opcode.

Behaviour:
- Opcodes: 0 NOP, 1 ALU, 2 LDI, 3 JMP, 4 BZ, F HALT; all others illegal.
- States: FETCH, WAIT, DECODE, EXEC, HALTED. State, ir, retired, timeout counter and fault are registers. All other outputs are combinational from state, ir and inputs.
- Reset (synchronous, dominates everything, including mid-fetch and HALTED):
  - state=FETCH, ir=0, retired=0, fault=0, timeout counter=0.
  - The first cycle after reset therefore shows imem_req=1, pc_en=0, pc_ld=0, rf_we=0, halted=0.
- FETCH: imem_req=1.
  - If imem_valid: ir<=imem_data, pc_en=1, pc_ld=0, → DECODE.
  - Else → WAIT, timeout counter<=0.
- WAIT: imem_req=1 held.
  - If imem_valid: ir<=imem_data, pc_en=1 (increment), → DECODE.
  - Else counter++. When counter reaches FETCH_TIMEOUT: fault<=1, → HALTED.
- DECODE: no strobes, one cycle. Illegal opcode: fault<=1, → HALTED (not retired). Else → EXEC.
- EXEC (one cycle, then → FETCH, retired++):
  - NOP: no strobes.
  - ALU, LDI: rf_we=1.
  - JMP: pc_en=1, pc_ld=1, pc_target=imm8.
  - BZ: if zero_flag sampled this cycle then as JMP, else no strobe.
  - HALT: retired++, → HALTED.
- HALTED: all strobes 0, imem_req=0, halted=1. Exit only by reset.
- PC increments exactly once per fetched instruction, in the cycle ir loads. Jump target overrides the already-incremented value in EXEC.
- stall=1 in FETCH/WAIT/DECODE/EXEC:
  - State, ir, retired and timeout counter hold.
  - pc_en=0, rf_we=0, no ir load; imem_valid arriving under stall is ignored.
  - imem_req stays asserted if in FETCH/WAIT.
  - stall has no effect in HALTED.
- retired wraps modulo 2^RET_CNT_W.
- pc_target is the raw imm8 bit pattern; the PC interprets it as signed.

Decomposition:
- Shared package pkg_cpu holds:
  - Opcode localparams OP_NOP, OP_ALU, OP_LDI, OP_JMP, OP_BZ, OP_HALT.
  - State encoding typedef (3-bit).
  - Instruction field slice constants.
- Optional sub-module fetch_timer: a WAIT cycle counter with clear and expire output.
- Everything else lives in one FSM module.

Test Plan:
- Reset, then imem returns NOP (0x0000) one cycle after each request → per instruction: pc_en pulses once with pc_ld=0; retired=1 after 4 cycles, 2 after 8.
- Fetch JMP 0x3005 → in EXEC: pc_en=1, pc_ld=1, pc_target=0x05; next state FETCH; retired+1.
- BZ 0x40F0 with zero_flag=0 → no pc_ld. Repeat with zero_flag=1 → pc_ld=1, pc_target=0xF0 (−16).
- Withhold imem_valid for FETCH_TIMEOUT=15 cycles in WAIT → fault=1, halted=1, imem_req=0. Then reset → fault=0, state FETCH, imem_req=1.
- Assert stall for 3 cycles during EXEC of ALU 0x1xxx → rf_we=0 throughout stall, then exactly one rf_we pulse. Also feed opcode 0x7 → fault=1, retired unchanged.
- HALT 0xF000 → halted=1 permanently, retired+1. Assert reset for one cycle mid-WAIT of a later run → next cycle state FETCH, retired=0.
